// File: rtl/pipe_pkg.sv
// Shared definitions for the issue stage and the ALU pipeline it feeds:
// instruction layout, func encodings, bubble constants and operand-use decode.
package pipe_pkg;

  localparam int unsigned INSTR_W  = 24;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned FUNC_LSB = 20;
  localparam int unsigned RD_LSB   = 16;
  localparam int unsigned RS1_LSB  = 12;
  localparam int unsigned RS2_LSB  = 8;
  localparam int unsigned ADDR_LSB = 0;

  typedef enum logic [3:0] {
    FUNC_ADD    = 4'd0,
    FUNC_SUB    = 4'd1,
    FUNC_AND    = 4'd2,
    FUNC_PASS_A = 4'd3,
    FUNC_PASS_B = 4'd4,
    FUNC_OR     = 4'd5,
    FUNC_XOR    = 4'd6,
    FUNC_SLT    = 4'd7,
    FUNC_NOT_A  = 4'd8,
    FUNC_NOT_B  = 4'd9,
    FUNC_INC_A  = 4'd10,
    FUNC_DEC_A  = 4'd11,
    FUNC_HALT   = 4'd15
  } func_e;

  localparam logic [3:0] ILLEGAL_LO = 4'd12;
  localparam logic [3:0] ILLEGAL_HI = 4'd14;

  localparam logic [REG_W-1:0] BUBBLE_FUNC = REG_W'(FUNC_PASS_A);
  localparam logic [REG_W-1:0] BUBBLE_REG  = '0;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [REG_W-1:0]  func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.func = w[FUNC_LSB +: REG_W];
    d.rd   = w[RD_LSB   +: REG_W];
    d.rs1  = w[RS1_LSB  +: REG_W];
    d.rs2  = w[RS2_LSB  +: REG_W];
    d.addr = w[ADDR_LSB +: ADDR_W];
    return d;
  endfunction

  function automatic logic uses_rs1(input logic [REG_W-1:0] func);
    logic u;
    u = 1'b0;
    case (func)
      FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_PASS_A, FUNC_OR, FUNC_XOR,
      FUNC_SLT, FUNC_NOT_A, FUNC_INC_A, FUNC_DEC_A: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [REG_W-1:0] func);
    logic u;
    u = 1'b0;
    case (func)
      FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_PASS_B, FUNC_OR, FUNC_XOR,
      FUNC_SLT, FUNC_NOT_B: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  // rd=0 is reserved for bubbles, so a program writing it is rejected.
  function automatic logic is_illegal(input instr_t i);
    return ((i.func >= ILLEGAL_LO) && (i.func <= ILLEGAL_HI)) || (i.rd == BUBBLE_REG);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// History of the last DEPTH issue slots ({valid, rd}) and the RAW comparators
// that flag a fetched instruction reading a register still in flight.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             hazard
);

  logic [DEPTH-1:0] hist_valid;
  logic [REG_W-1:0] hist_rd [DEPTH];

  // Every slot shifts in, bubbles as invalid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hist_rd[i] <= '0;
    end else begin
      hist_valid[0] <= push_valid;
      hist_rd[0]    <= push_rd;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_rd[i]    <= hist_rd[i-1];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (hist_valid[i] && ((use_rs1 && (rs1 == hist_rd[i])) ||
                            (use_rs2 && (rs2 == hist_rd[i])))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_decode_unit.sv
// Fetch/decode/issue stage: loadable IMEM, PC sequencing, RAW stall bubbles,
// HALT drain and illegal-instruction handling ahead of the ALU pipeline.
module issue_decode_unit
  import pipe_pkg::*;
#(
  parameter int unsigned HAZARD_DEPTH = 2,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [7:0]  BUBBLE_ADDR  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               hold,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   func,
  output logic [ADDR_W-1:0]  addr,
  output logic               issue_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [15:0]        issued_count
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam instr_t BUBBLE = '{func: BUBBLE_FUNC, rd: BUBBLE_REG, rs1: BUBBLE_REG,
                                rs2: BUBBLE_REG, addr: BUBBLE_ADDR};

  logic [INSTR_W-1:0] imem [256];

  state_t             state, state_n;
  instr_t             out_q, out_n, fetch;
  logic               valid_n, illegal_n, load_ok, hazard;
  logic [ADDR_W-1:0]  pc_n;
  logic [15:0]        count_n;
  logic [DRAIN_W-1:0] drain_q, drain_n;

  assign fetch = decode(imem[pc]);

  hazard_scoreboard #(.DEPTH(HAZARD_DEPTH)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .push_valid (valid_n),
    .push_rd    (out_n.rd),
    .rs1        (fetch.rs1),
    .rs2        (fetch.rs2),
    .use_rs1    (uses_rs1(fetch.func)),
    .use_rs2    (uses_rs2(fetch.func)),
    .hazard     (hazard)
  );

  // IMEM is not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_q        <= BUBBLE;
      issue_valid  <= 1'b0;
      pc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      issued_count <= '0;
      drain_q      <= '0;
    end else begin
      state        <= state_n;
      out_q        <= out_n;
      issue_valid  <= valid_n;
      pc           <= pc_n;
      busy         <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done         <= (state_n == ST_DONE);
      illegal      <= illegal_n;
      issued_count <= count_n;
      drain_q      <= drain_n;
    end
  end

  // Priority within RUN: HALT > illegal > hold > hazard > issue.
  always_comb begin
    state_n   = state;
    out_n     = BUBBLE;
    valid_n   = 1'b0;
    pc_n      = pc;
    illegal_n = illegal;
    count_n   = issued_count;
    drain_n   = drain_q;
    load_ok   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        load_ok = 1'b1;
        if (start) begin
          state_n   = ST_RUN;
          pc_n      = start_pc;
          illegal_n = 1'b0;
          count_n   = '0;
        end
      end
      ST_RUN: begin
        if (fetch.func == FUNC_HALT) begin
          state_n = ST_DRAIN;
          drain_n = '0;
        end else if (is_illegal(fetch)) begin
          illegal_n = 1'b1;
          pc_n      = pc + ADDR_W'(1);
        end else if (!hold && !hazard) begin
          out_n   = fetch;
          valid_n = 1'b1;
          pc_n    = pc + ADDR_W'(1);
          if (issued_count != 16'hFFFF) count_n = issued_count + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_n = ST_DONE;
        else drain_n = drain_q + DRAIN_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign func = out_q.func;
  assign rd   = out_q.rd;
  assign rs1  = out_q.rs1;
  assign rs2  = out_q.rs2;
  assign addr = out_q.addr;

endmodule

// File: tb/tb_issue_decode_unit.sv
// Directed bench for issue_decode_unit: issue flow, RAW stalls, illegal,
// PC wrap, hold freeze and asynchronous reset during drain.
module tb_issue_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [23:0] load_data;
  logic        start;
  logic [7:0]  start_pc;
  logic        hold;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, pc;
  logic        issue_valid, busy, done, illegal;
  logic [15:0] issued_count;

  int n_tests = 0;
  int n_fail  = 0;

  issue_decode_unit dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .start_pc     (start_pc),
    .hold         (hold),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .func         (func),
    .addr         (addr),
    .issue_valid  (issue_valid),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ins(input logic [3:0] f, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [7:0] m);
    return {f, d, a, b, m};
  endfunction

  task automatic load(input logic [7:0] a, input logic [23:0] w);
    load_en = 1'b1; load_addr = a; load_data = w;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] p);
    start = 1'b1; start_pc = p;
    tick();
    start = 1'b0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 32'(issue_valid), 32'd0);
    check({tag, "_func"},  32'(func), 32'd3);
    check({tag, "_rd"},    32'(rd),   32'd0);
    check({tag, "_addr"},  32'(addr), 32'hFF);
  endtask

  task automatic check_issue(input string tag, input logic [3:0] ef, input logic [3:0] ed,
                             input logic [3:0] ea, input logic [3:0] eb, input logic [7:0] em);
    check({tag, "_valid"}, 32'(issue_valid), 32'd1);
    check({tag, "_func"},  32'(func), 32'(ef));
    check({tag, "_rd"},    32'(rd),   32'(ed));
    check({tag, "_rs1"},   32'(rs1),  32'(ea));
    check({tag, "_rs2"},   32'(rs2),  32'(eb));
    check({tag, "_addr"},  32'(addr), 32'(em));
  endtask

  // Called just after the HALT bubble edge; done rises on the 4th drain edge.
  task automatic drain(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({tag, "_drain_bubble"}, 32'(issue_valid), 32'd0);
      check({tag, "_done"}, 32'(done), 32'(i == 4));
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_pc = '0; hold = 1'b0;
    tick(); tick();
    check_bubble("rst");
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_count", 32'(issued_count), 32'd0);
    rst = 1'b0;
    tick();

    // Basic flow: add, or, HALT
    load(8'h00, ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h10));
    load(8'h01, ins(4'd5, 4'd4, 4'd5, 4'd6, 8'h11));
    load(8'h02, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    start_at(8'h00);
    check("t1_pc0", 32'(pc), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_start_bubble", 32'(issue_valid), 32'd0);
    tick();
    check_issue("t1_add", 4'd0, 4'd1, 4'd2, 4'd3, 8'h10);
    check("t1_pc1", 32'(pc), 32'd1);
    tick();
    check_issue("t1_or", 4'd5, 4'd4, 4'd5, 4'd6, 8'h11);
    tick();
    check_bubble("t1_halt");
    check("t1_halt_pc", 32'(pc), 32'd2);
    check("t1_halt_done", 32'(done), 32'd0);
    drain("t1");
    check("t1_count", 32'(issued_count), 32'd2);

    // RAW hazard: sub reads r1 right after add writes it
    load(8'h10, ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h20));
    load(8'h11, ins(4'd1, 4'd4, 4'd1, 4'd5, 8'h21));
    load(8'h12, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    start_at(8'h10);
    tick();
    check_issue("t2_add", 4'd0, 4'd1, 4'd2, 4'd3, 8'h20);
    tick();
    check_bubble("t2_stall1");
    check("t2_stall1_pc", 32'(pc), 32'h11);
    tick();
    check_bubble("t2_stall2");
    check("t2_stall2_pc", 32'(pc), 32'h11);
    tick();
    check_issue("t2_sub", 4'd1, 4'd4, 4'd1, 4'd5, 8'h21);
    tick();
    check_bubble("t2_halt");
    drain("t2");

    // Illegal func 13 at PC 5
    load(8'h04, ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h30));
    load(8'h05, ins(4'd13, 4'd2, 4'd0, 4'd0, 8'h31));
    load(8'h06, ins(4'd2, 4'd9, 4'd10, 4'd11, 8'h32));
    load(8'h07, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    start_at(8'h04);
    tick();
    check_issue("t4_add", 4'd0, 4'd1, 4'd2, 4'd3, 8'h30);
    tick();
    check_bubble("t4_ill");
    check("t4_ill_flag", 32'(illegal), 32'd1);
    check("t4_ill_pc", 32'(pc), 32'd6);
    tick();
    check_issue("t4_and", 4'd2, 4'd9, 4'd10, 4'd11, 8'h32);
    check("t4_sticky", 32'(illegal), 32'd1);
    tick();
    check_bubble("t4_halt");
    drain("t4");
    check("t4_count", 32'(issued_count), 32'd2);

    // Unused rs1 for func 4 must not stall; new start clears illegal
    load(8'h20, ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h40));
    load(8'h21, ins(4'd4, 4'd7, 4'd1, 4'd8, 8'h41));
    load(8'h22, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    start_at(8'h20);
    check("t3_ill_clear", 32'(illegal), 32'd0);
    check("t3_count_clear", 32'(issued_count), 32'd0);
    tick();
    check_issue("t3_add", 4'd0, 4'd1, 4'd2, 4'd3, 8'h40);
    tick();
    check_issue("t3_mov", 4'd4, 4'd7, 4'd1, 4'd8, 8'h41);
    check("t3_pc", 32'(pc), 32'h22);
    tick();
    check_bubble("t3_halt");
    drain("t3");

    // PC wrap; the FF word is loaded in the same cycle as start
    load(8'h00, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    load_en = 1'b1; load_addr = 8'hFF; load_data = ins(4'd6, 4'd3, 4'd4, 4'd5, 8'h50);
    start = 1'b1; start_pc = 8'hFF;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("t5_pc_ff", 32'(pc), 32'hFF);
    tick();
    check_issue("t5_xor", 4'd6, 4'd3, 4'd4, 4'd5, 8'h50);
    check("t5_wrap", 32'(pc), 32'h00);
    tick();
    check_bubble("t5_halt");
    check("t5_halt_pc", 32'(pc), 32'h00);
    drain("t5");
    check("t5_count", 32'(issued_count), 32'd1);

    // hold for 3 cycles, then reset mid-drain
    load(8'h40, ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h60));
    load(8'h41, ins(4'd5, 4'd4, 4'd5, 4'd6, 8'h61));
    load(8'h42, ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
    start_at(8'h40);
    tick();
    check_issue("t6_add", 4'd0, 4'd1, 4'd2, 4'd3, 8'h60);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bubble("t6_hold");
      check("t6_hold_pc", 32'(pc), 32'h41);
    end
    hold = 1'b0;
    tick();
    check_issue("t6_or", 4'd5, 4'd4, 4'd5, 4'd6, 8'h61);
    tick();
    check_bubble("t6_halt");
    tick();
    check("t6_in_drain", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_bubble("t6_arst");
    check("t6_arst_pc", 32'(pc), 32'd0);
    check("t6_arst_busy", 32'(busy), 32'd0);
    check("t6_arst_done", 32'(done), 32'd0);
    check("t6_arst_count", 32'(issued_count), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_done", 32'(done), 32'd0);
    check("t6_idle_valid", 32'(issue_valid), 32'd0);
    start_at(8'h40);
    check("t6_restart_busy", 32'(busy), 32'd1);
    tick();
    check_issue("t6_imem_kept", 4'd0, 4'd1, 4'd2, 4'd3, 8'h60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
